// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared operation encodings for the register bank and its ALU.
package reg_bank_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_LOAD = 2'b00;
    localparam op_t OP_ADD  = 2'b01;
    localparam op_t OP_SUB  = 2'b10;
    localparam op_t OP_SHL  = 2'b11;

endpackage

// File: rtl/reg_bank_alu.sv
// reg_bank_alu: combinational in-place operation applied to one register.
// Produces the new register value plus carry / signed-overflow / zero flags.
// SUB reports carry=1 when a borrow occurred (inverted adder carry-out).
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] operand_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             zero_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;
    logic           sum_cin_msb;
    logic           dif_cin_msb;

    // Select the operation result and derive carry and signed overflow.
    always_comb begin
        sum         = {1'b0, operand_i} + {1'b0, wdata_i};
        dif         = {1'b0, operand_i} + {1'b0, ~wdata_i} + {{WIDTH{1'b0}}, 1'b1};
        // Carry into the MSB recovered from the MSB sum bit and its two inputs.
        sum_cin_msb = sum[WIDTH-1] ^ operand_i[WIDTH-1] ^ wdata_i[WIDTH-1];
        dif_cin_msb = dif[WIDTH-1] ^ operand_i[WIDTH-1] ^ ~wdata_i[WIDTH-1];
        result_o    = operand_i;
        carry_o     = 1'b0;
        overflow_o  = 1'b0;
        case (op_i)
            OP_LOAD: begin
                result_o = wdata_i;
            end
            OP_ADD: begin
                result_o   = sum[WIDTH-1:0];
                carry_o    = sum[WIDTH];
                overflow_o = sum[WIDTH] ^ sum_cin_msb;
            end
            OP_SUB: begin
                result_o   = dif[WIDTH-1:0];
                carry_o    = ~dif[WIDTH];
                overflow_o = dif[WIDTH] ^ dif_cin_msb;
            end
            default: begin
                result_o = {operand_i[WIDTH-2:0], wdata_i[0]};
                carry_o  = operand_i[WIDTH-1];
            end
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register bank with one read-modify-write port
// (LOAD/ADD/SUB/SHL), two combinational read ports and registered flags.
// Optional macro REG_BANK_BYPASS_EN forwards the in-flight write result to a
// read port addressing the register being written in the same cycle.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             we,
    input  op_t              op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] operand;
    logic             wr_hit;
    logic             wr_en;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_z;

    // Fetch the addressed register; an address past DEPTH never hits.
    always_comb begin
        operand = '0;
        wr_hit  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
                operand = regs_q[i];
                wr_hit  = 1'b1;
            end
        end
    end

    assign wr_en = we & wr_hit;

    reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .operand_i  (operand),
        .wdata_i    (wdata),
        .op_i       (op),
        .result_o   (alu_res),
        .carry_o    (alu_c),
        .overflow_o (alu_v),
        .zero_o     (alu_z)
    );

    // Next state: only an accepted write touches the target register and flags.
    always_comb begin
        regs_d     = regs_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        if (wr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (waddr == AW'(i)) regs_d[i] = alu_res;
            end
            carry_d    = alu_c;
            overflow_d = alu_v;
            zero_d     = alu_z;
        end
    end

    // State registers; reset clears data and flags and overrides any write.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    // Read muxes; out-of-range addresses read as zero.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) rdata_a = regs_q[i];
            if (raddr_b == AW'(i)) rdata_b = regs_q[i];
        end
`ifdef REG_BANK_BYPASS_EN
        if (Reset && wr_en && (raddr_a == waddr)) rdata_a = alu_res;
        if (Reset && wr_en && (raddr_b == waddr)) rdata_b = alu_res;
`endif
    end

    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule
